// File: rtl/fprop_tile_p.sv
// Two-layer fully-connected forward-propagation tile: LANES shared MAC lanes,
// streamed pixels and weights in, activated results streamed out.
module fprop_tile_p #(
    parameter int IN_SZ  = 784,
    parameter int HID_SZ = 128,
    parameter int OUT_SZ = 10,
    parameter int LANES  = 8,
    parameter int DW     = 16,
    parameter int FRAC   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  act_mode,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  in_ready,
    input  logic                  w_valid,
    input  logic [LANES*DW-1:0]   w_data,
    output logic                  w_ready,
    output logic                  w_layer,
    output logic                  out_valid,
    output logic [DW-1:0]         out_data,
    input  logic                  out_ready
);

    localparam int MAXN = (IN_SZ > HID_SZ) ? IN_SZ : HID_SZ;
    localparam int AW   = 2*DW + $clog2(MAXN);
    localparam int NG0  = HID_SZ / LANES;
    localparam int NG1  = (OUT_SZ + LANES - 1) / LANES;
    localparam int MAXG = (NG0 > NG1) ? NG0 : NG1;
    localparam int RSZ  = NG1 * LANES;
    localparam int KW   = (MAXN > 1)   ? $clog2(MAXN)   : 1;
    localparam int IKW  = (IN_SZ > 1)  ? $clog2(IN_SZ)  : 1;
    localparam int HKW  = (HID_SZ > 1) ? $clog2(HID_SZ) : 1;
    localparam int RKW  = (RSZ > 1)    ? $clog2(RSZ)    : 1;
    localparam int GW   = (MAXG > 1)   ? $clog2(MAXG)   : 1;
    localparam int NW   = (OUT_SZ > 1) ? $clog2(OUT_SZ) : 1;

    localparam logic signed [AW-1:0] MAXV = AW'((64'd1 << (DW-1)) - 64'd1);
    localparam logic signed [AW-1:0] ONE  = AW'(64'd1 << FRAC);
    localparam logic signed [AW-1:0] HALF = AW'(64'd1 << (FRAC-1));

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_L0   = 3'd2;
    localparam logic [2:0] S_ACT0 = 3'd3;
    localparam logic [2:0] S_L1   = 3'd4;
    localparam logic [2:0] S_ACT1 = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;

    if (HID_SZ % LANES != 0) begin : g_bad_lanes
        $error("fprop_tile_p: HID_SZ must be a multiple of LANES");
    end

    logic [2:0]             state;
    logic                   mode;
    logic                   done_q;
    logic [KW-1:0]          k;
    logic [KW-1:0]          k_last;
    logic [GW-1:0]          g;
    logic [NW-1:0]          n;
    logic signed [AW-1:0]   acc  [LANES];
    logic signed [2*DW-1:0] prod [LANES];
    logic signed [DW-1:0]   x;

    logic [DW-1:0] in_buf  [IN_SZ];
    logic [DW-1:0] hid_buf [HID_SZ];
    logic [DW-1:0] res_buf [RSZ];

    function automatic logic [DW-1:0] act(input logic signed [AW-1:0] a, input logic m);
        logic signed [AW-1:0] v;
        logic signed [AW-1:0] s;
        v = a >>> FRAC;
        if (m) begin
            s = (v >>> 2) + HALF;
            if (s < 0)
                s = '0;
            else if (s > ONE)
                s = ONE;
        end else begin
            s = (v < 0) ? '0 : v;
        end
        if (s > MAXV)
            s = MAXV;
        return s[DW-1:0];
    endfunction

    always_comb begin
        x      = (state == S_L1) ? hid_buf[HKW'(k)] : in_buf[IKW'(k)];
        k_last = (state == S_L1) ? KW'(HID_SZ - 1) : KW'(IN_SZ - 1);
        for (int unsigned j = 0; j < LANES; j++)
            prod[j] = $signed(w_data[j*DW +: DW]) * x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            mode   <= 1'b0;
            done_q <= 1'b0;
            k      <= '0;
            g      <= '0;
            n      <= '0;
            for (int unsigned j = 0; j < LANES; j++)
                acc[j] <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state <= S_LOAD;
                    mode  <= act_mode;
                    k     <= '0;
                    g     <= '0;
                end
                S_LOAD: if (in_valid) begin
                    if (k == KW'(IN_SZ - 1)) begin
                        k     <= '0;
                        state <= S_L0;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_L0, S_L1: if (w_valid) begin
                    for (int unsigned j = 0; j < LANES; j++)
                        acc[j] <= acc[j] + AW'(prod[j]);
                    if (k == k_last) begin
                        k     <= '0;
                        state <= (state == S_L0) ? S_ACT0 : S_ACT1;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_ACT0, S_ACT1: begin
                    for (int unsigned j = 0; j < LANES; j++)
                        acc[j] <= '0;
                    if (state == S_ACT0 && g == GW'(NG0 - 1)) begin
                        g     <= '0;
                        state <= S_L1;
                    end else if (state == S_ACT1 && g == GW'(NG1 - 1)) begin
                        g     <= '0;
                        n     <= '0;
                        state <= S_OUT;
                    end else begin
                        g     <= g + 1'b1;
                        state <= (state == S_ACT0) ? S_L0 : S_L1;
                    end
                end
                S_OUT: if (out_ready) begin
                    if (n == NW'(OUT_SZ - 1)) begin
                        n      <= '0;
                        state  <= S_IDLE;
                        done_q <= 1'b1;
                    end else begin
                        n <= n + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffers hold no reset: every entry is rewritten before it is read in a run.
    always_ff @(posedge clk) begin
        if (state == S_LOAD && in_valid)
            in_buf[IKW'(k)] <= in_data;
        if (state == S_ACT0)
            for (int unsigned j = 0; j < LANES; j++)
                hid_buf[HKW'(int'(g) * LANES + j)] <= act(acc[j], mode);
        if (state == S_ACT1)
            for (int unsigned j = 0; j < LANES; j++)
                res_buf[RKW'(int'(g) * LANES + j)] <= act(acc[j], mode);
    end

    always_comb begin
        busy      = (state != S_IDLE) || done_q;
        done      = done_q;
        in_ready  = (state == S_LOAD);
        w_ready   = (state == S_L0) || (state == S_L1);
        w_layer   = (state == S_L1);
        out_valid = (state == S_OUT);
        out_data  = out_valid ? res_buf[RKW'(n)] : '0;
    end

endmodule
